// File: rtl/op_resta_serial.sv
// op_resta_serial: bit-serial subtractor computing Res = A - B - Bin (mod 2^N),
// one bit per clock, LSB first, with unsigned borrow-out, signed overflow and
// zero flags.
//
// Ports:
//   clk   - system clock, rising edge active
//   rst_n - asynchronous active-low reset
//   start - request a new subtraction (accepted in IDLE or DONE)
//   A, B  - minuend / subtrahend, captured on accept
//   Bin   - borrow-in, captured on accept
//   Res   - result, valid from the done pulse until the next done pulse
//   Bout  - unsigned borrow-out (A < B + Bin)
//   v     - two's-complement overflow of A - B - Bin
//   z     - Res == 0
//   busy  - high while bits are being processed
//   done  - one-cycle pulse when Res/Bout/v/z update
module op_resta_serial #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic [N-1:0] Res,
  output logic         Bout,
  output logic         v,
  output logic         z,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic            busy_d, done_d;

  logic [N-1:0]    a_sh, b_sh, d_sh;
  logic            br;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            last;
  logic            d_bit;
  logic            br_nx;
  logic [N-1:0]    res_nx;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(N - 1));

  // One-bit full subtractor on the current LSBs
  assign d_bit  = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nx  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign res_nx = {d_bit, d_sh[N-1:1]};

  // State register, plus registered busy/done decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode (registered in the state process)
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_n)
      RUN:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shift registers, borrow, bit counter and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      d_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      Res  <= '0;
      Bout <= 1'b0;
      v    <= 1'b0;
      z    <= 1'b0;
    end else if (accept) begin
      a_sh <= A;
      b_sh <= B;
      br   <= Bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= res_nx;
      br   <= br_nx;
      // Counter stops at N after the last bit, so it never wraps
      cnt  <= cnt + CW'(1);
      if (last) begin
        Res  <= res_nx;
        Bout <= br_nx;
        // br here is the borrow into the MSB
        v    <= br ^ br_nx;
        z    <= (res_nx == '0);
      end
    end
  end

endmodule

// File: tb/tb_op_resta_serial.sv
// Directed self-checking bench for op_resta_serial (N = 4).
module tb_op_resta_serial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A, B;
  logic       Bin;
  logic [3:0] Res;
  logic       Bout, v, z, busy, done;

  int tests;
  int errs;
  int pulses;

  op_resta_serial #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Res   (Res),
    .Bout  (Bout),
    .v     (v),
    .z     (z),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] r, input logic bo,
                          input logic vv, input logic zz);
    chk({tag, ".res"},  32'(Res),  32'(r));
    chk({tag, ".bout"}, 32'(Bout), 32'(bo));
    chk({tag, ".v"},    32'(v),    32'(vv));
    chk({tag, ".z"},    32'(z),    32'(zz));
  endtask

  // Full operation: accept edge, 3 busy edges, done on the 4th bit edge, then idle
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic bi, input logic [3:0] r, input logic bo,
                       input logic vv, input logic zz);
    A = a; B = b; Bin = bi; start = 1'b1;
    step();
    start = 1'b0;
    A = ~a; B = ~b; Bin = ~bi;
    chk({tag, ".busy0"}, 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, ".nodone"}, 32'(done), 32'd0);
    end
    step();
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busyd"}, 32'(busy), 32'd0);
    chk_outs(tag, r, bo, vv, zz);
    step();
    chk({tag, ".pulse1"}, 32'(done), 32'd0);
    chk_outs({tag, ".hold"}, r, bo, vv, zz);
  endtask

  initial begin
    tests = 0; errs = 0; pulses = 0;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk_outs("rst", 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    do_op("op7m2",  4'b0111, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0);
    do_op("op2m7",  4'b0010, 4'b0111, 1'b0, 4'b1011, 1'b1, 1'b0, 1'b0);
    do_op("op7mF",  4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0);
    do_op("op8m1",  4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0);
    do_op("op0b1",  4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    do_op("op5m5",  4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

    // start pulsed again mid-run with different operands is ignored
    A = 4'b0111; B = 4'b0010; Bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    pulses = 0;
    chk("ign.busy0", 32'(busy), 32'd1);
    step();
    chk("ign.busy1", 32'(busy), 32'd1);
    step();
    chk("ign.busy2", 32'(busy), 32'd1);
    A = 4'b1111; B = 4'b0000; Bin = 1'b1; start = 1'b1;
    step();
    chk("ign.busy3", 32'(busy), 32'd1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) begin
        chk("ign.busyend", 32'(busy), 32'd0);
        chk_outs("ign", 4'b0101, 1'b0, 1'b0, 1'b0);
      end
      if (done) pulses++;
    end
    chk("ign.pulses", 32'(pulses), 32'd1);

    // start held high: back-to-back results every 5 cycles
    A = 4'b0111; B = 4'b0010; Bin = 1'b0; start = 1'b1;
    step();
    A = 4'b0010; B = 4'b0111;
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (done) pulses++;
      if (i == 4) begin
        chk("b2b.done1", 32'(done), 32'd1);
        chk_outs("b2b.r1", 4'b0101, 1'b0, 1'b0, 1'b0);
      end else if (i >= 5 && i <= 8) begin
        chk("b2b.busy", 32'(busy), 32'd1);
        chk("b2b.holdres", 32'(Res), 32'(4'b0101));
      end else if (i == 9) begin
        chk("b2b.done2", 32'(done), 32'd1);
        chk_outs("b2b.r2", 4'b1011, 1'b1, 1'b0, 1'b0);
      end
    end
    chk("b2b.pulses", 32'(pulses), 32'd2);
    start = 1'b0;
    step();
    chk("b2b.idle", 32'(done), 32'd0);

    // Asynchronous reset mid-run: immediate clear, no done pulse afterwards
    A = 4'b0111; B = 4'b0010; Bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    chk_outs("arst", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy) pulses++;
    end
    chk("arst.quiet", 32'(pulses), 32'd0);
    do_op("post", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
